alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered successor to the single-cycle 16-bit WISC ALU. Executes the 16 WISC opcodes on WIDTH-bit
//  operands and registers result + {N,V,Z} flag register behind a valid/ready handshake, so EX can stall and flush.
//  Sits between the ID/EX operand muxes and the EX/MEM boundary; the flag register feeds branch resolution.
// PARAMETERS
//  WIDTH     16  datapath width; legal 16, 32, 64 (multiple of 8, >=16)
//  SAT_ARITH 1   1: ADD/SUB saturate to signed WIDTH range; 0: wrap
//  SHW       $clog2(WIDTH) (localparam, not overridable) shift-amount width
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  flush      in   1      squash in-flight result (branch mispredict)
//  in_valid   in   1      opcode/operands valid
//  in_ready   out  1      block can accept this cycle
//  opcode     in   4      WISC opcode (0000 ADD .. 1111 HLT)
//  alu_in1    in   WIDTH  operand 1 (rs / base)
//  alu_in2    in   WIDTH  operand 2 (rt / imm / shamt)
//  out_valid  out  1      alu_out valid
//  out_ready  in   1      consumer accepts alu_out
//  alu_out    out  WIDTH  registered result
//  flag       out  3      registered flag register {N,V,Z} (bit2=N, bit1=V, bit0=Z)
// BEHAVIOUR
//  Reset: out_valid=0, alu_out=0, flag=3'b000; in_ready=1 once rst_n deasserts. rst_n low mid-operation discards result.
//  Handshake: accept = in_valid & in_ready; in_ready = ~flush & (~out_valid | out_ready). Latency 1: accepted op
//   appears on alu_out with out_valid=1 next cycle. alu_out/out_valid hold while out_valid & ~out_ready.
//   Full throughput: back-to-back accept when out_ready=1 every cycle.
//  Flush: next cycle out_valid=0; no accept on a flush cycle (flush beats in_valid); flag register NOT rolled back.
//  Flags update on accept edge only, per opcode class; others hold:
//   ADD/SUB: N,V,Z all; V=signed overflow of true result (set even when saturated); Z,N from post-sat result.
//   XOR/SLL/SRA/ROR: Z only. RED, PADDSB, LW, SW, LLB, LHB, B, BR, PCS, HLT: no update.
//  Arithmetic (result, all WIDTH bits):
//   ADD/SUB: in1 +/- in2; overflow -> 0111..1 / 1000..0 if SAT_ARITH=1 else wrap.
//   XOR: in1 ^ in2.  RED: signed sum of all 2*WIDTH/8 bytes of in1,in2, sign-extended to WIDTH.
//   SLL/SRA/ROR: in1 shifted/rotated by in2[SHW-1:0]; amount 0 -> in1 unchanged.
//   PADDSB: per 4-bit nibble signed add, each lane saturates to 0111/1000 independently.
//   LW/SW: in1 + in2 wrapping (address), never saturated.
//   LLB: {in1[WIDTH-1:8], in2[7:0]}. LHB: in1 with bits[15:8] replaced by in2[7:0].
//   B/BR/PCS/HLT: alu_out = in1 (pass-through).
//  Opcode is registered with operands; no X on alu_out for any legal opcode.
// STRUCTURE
//  Package alu_pkg: opcode localparams (OP_ADD..OP_HLT), flag indices FLAG_N=2/FLAG_V=1/FLAG_Z=0,
//   function flag_mask(opcode) returning 3-bit update-enable.
//  Sub-module alu_core (combinational, WIDTH/SAT_ARITH params): opcode+operands -> result, next_flags.
//  alu_pipe: handshake, output register, flag register, flush logic.
// TESTING
//  1 WIDTH=16: ADD 0x7FFF+0x0001, out_ready=1 -> next cycle alu_out=0x7FFF, flag={N0,V1,Z0}; SAT_ARITH=0 -> 0x8000, flag=3'b110.
//  2 SUB 0x1234-0x1234 -> alu_out=0, flag=3'b001; then XOR 0xFF00^0x00FF -> 0xFFFF, flag=3'b000 (N,V held 0, Z cleared).
//  3 Backpressure: 3 ops accepted, out_ready=0 for 4 cycles -> in_ready=0, alu_out stable; release -> 2 results 1/cycle, none lost/duplicated.
//  4 Flush with in_valid=1 and out_valid=1 -> in_ready=0 that cycle, next out_valid=0, flag unchanged.
//  5 WIDTH=32: ROR 0x8000_0001 by 1 -> 0xC000_0000; SRA 0x8000_0000 by 31 -> 0xFFFF_FFFF; PADDSB 0x7777_7777+0x1111_1111 -> 0x7777_7777.
//  6 rst_n pulsed low while out_valid=1, flag=3'b111 -> out_valid, alu_out, flag go 0 immediately (async), no clock needed.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and the per-opcode flag
// update mask used by the WISC ALU pipeline stage.
package alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LLB    = 4'b1010;
  localparam logic [3:0] OP_LHB    = 4'b1011;
  localparam logic [3:0] OP_B      = 4'b1100;
  localparam logic [3:0] OP_BR     = 4'b1101;
  localparam logic [3:0] OP_PCS    = 4'b1110;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  // Which of {N,V,Z} an opcode is allowed to write; all other bits hold.
  function automatic logic [2:0] flag_mask(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB:                 flag_mask = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_mask = 3'b001;
      default:                        flag_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational WISC ALU: opcode + operands -> result and candidate {N,V,Z}.
// The pipeline stage decides which candidate flags are actually committed.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit SAT_ARITH = 1'b1
) (
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       next_flags
);

  localparam int SHW = $clog2(WIDTH);
  localparam int NB  = 2 * WIDTH / 8;
  localparam int NN  = WIDTH / 4;

  logic [WIDTH-1:0]   sum, diff, max_pos, min_neg, red, padd;
  logic [2*WIDTH-1:0] both;
  logic [SHW-1:0]     amt;
  logic [4:0]         nsum;
  logic               add_ovf, sub_ovf, ovf;

  always_comb begin
    sum     = in1 + in2;
    diff    = in1 - in2;
    add_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
    sub_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
    max_pos = {1'b0, {(WIDTH-1){1'b1}}};
    min_neg = ~max_pos;
    amt     = in2[SHW-1:0];

    // Byte reduction over both operands; the accumulator is wide enough
    // that the signed sum can never overflow for WIDTH >= 16.
    both = {in1, in2};
    red  = '0;
    for (int i = 0; i < NB; i++)
      red = red + {{(WIDTH-8){both[i*8+7]}}, both[i*8 +: 8]};

    nsum = '0;
    padd = '0;
    for (int j = 0; j < NN; j++) begin
      nsum = {in1[j*4+3], in1[j*4 +: 4]} + {in2[j*4+3], in2[j*4 +: 4]};
      if (nsum[4] != nsum[3]) padd[j*4 +: 4] = nsum[4] ? 4'b1000 : 4'b0111;
      else                    padd[j*4 +: 4] = nsum[3:0];
    end

    case (opcode)
      OP_ADD:    result = (SAT_ARITH && add_ovf) ? (in1[WIDTH-1] ? min_neg : max_pos) : sum;
      OP_SUB:    result = (SAT_ARITH && sub_ovf) ? (in1[WIDTH-1] ? min_neg : max_pos) : diff;
      OP_XOR:    result = in1 ^ in2;
      OP_RED:    result = red;
      OP_SLL:    result = in1 << amt;
      OP_SRA:    result = $signed(in1) >>> amt;
      OP_ROR:    result = WIDTH'({in1, in1} >> amt);
      OP_PADDSB: result = padd;
      OP_LW,
      OP_SW:     result = sum;
      OP_LLB:    result = {in1[WIDTH-1:8], in2[7:0]};
      OP_LHB: begin
        result        = in1;
        result[15:8]  = in2[7:0];
      end
      default:   result = in1;
    endcase

    ovf = (opcode == OP_SUB) ? sub_ovf : add_ovf;
    next_flags[FLAG_N] = result[WIDTH-1];
    next_flags[FLAG_V] = ovf;
    next_flags[FLAG_Z] = (result == '0);
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered WISC ALU stage: one-deep output register behind valid/ready,
// with flush squash and a flag register that only moves on accepted ops.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit SAT_ARITH = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] alu_in1,
  input  logic [WIDTH-1:0] alu_in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [2:0]       flag
);

  logic [WIDTH-1:0] result;
  logic [2:0]       next_flags, mask;
  logic             accept;

  alu_core #(.WIDTH(WIDTH), .SAT_ARITH(SAT_ARITH)) u_core (
    .opcode     (opcode),
    .in1        (alu_in1),
    .in2        (alu_in2),
    .result     (result),
    .next_flags (next_flags)
  );

  // Flush blocks acceptance outright so a squashed cycle never loads.
  assign in_ready = ~flush & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign mask     = flag_mask(opcode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_out   <= '0;
      flag      <= 3'b000;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      alu_out   <= result;
      flag      <= (flag & ~mask) | (next_flags & mask);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: 16-bit saturating and wrapping instances
// share stimulus; a 32-bit instance covers shifts, PADDSB and RED.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0]  opcode = 4'h0;
  logic [15:0] in1 = '0, in2 = '0;
  logic        rdy_a, vld_a, rdy_b, vld_b;
  logic [15:0] out_a, out_b;
  logic [2:0]  flag_a, flag_b;

  logic        v32 = 1'b0;
  logic [3:0]  op32 = 4'h0;
  logic [31:0] a32 = '0, b32 = '0, out32;
  logic        rdy32, vld32;
  logic [2:0]  flag32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(16), .SAT_ARITH(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
    .opcode(opcode), .alu_in1(in1), .alu_in2(in2), .out_valid(vld_a),
    .out_ready(out_ready), .alu_out(out_a), .flag(flag_a));

  alu_pipe #(.WIDTH(16), .SAT_ARITH(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
    .opcode(opcode), .alu_in1(in1), .alu_in2(in2), .out_valid(vld_b),
    .out_ready(out_ready), .alu_out(out_b), .flag(flag_b));

  alu_pipe #(.WIDTH(32), .SAT_ARITH(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(v32), .in_ready(rdy32),
    .opcode(op32), .alu_in1(a32), .alu_in2(b32), .out_valid(vld32),
    .out_ready(1'b1), .alu_out(out32), .flag(flag32));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
    in_valid = 1'b1; opcode = op; in1 = x; in2 = y;
    step();
  endtask

  task automatic issue32(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    v32 = 1'b1; op32 = op; a32 = x; b32 = y;
    step();
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_valid", 64'(vld_a), 64'd0);
    chk("rst_out",   64'(out_a), 64'd0);
    chk("rst_flag",  64'(flag_a), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 64'(rdy_a), 64'd1);

    // Signed overflow: saturate vs wrap
    issue(4'b0000, 16'h7FFF, 16'h0001);
    chk("add_sat_out",   64'(out_a), 64'h7FFF);
    chk("add_sat_flag",  64'(flag_a), 64'b010);
    chk("add_sat_vld",   64'(vld_a), 64'd1);
    chk("add_wrap_out",  64'(out_b), 64'h8000);
    chk("add_wrap_flag", 64'(flag_b), 64'b110);

    issue(4'b0001, 16'h1234, 16'h1234);
    chk("sub_zero_out",  64'(out_a), 64'h0000);
    chk("sub_zero_flag", 64'(flag_a), 64'b001);

    issue(4'b0010, 16'hFF00, 16'h00FF);
    chk("xor_out",  64'(out_a), 64'hFFFF);
    chk("xor_flag", 64'(flag_a), 64'b000);

    issue(4'b0000, 16'h8000, 16'hFFFF);
    chk("add_neg_sat_out",   64'(out_a), 64'h8000);
    chk("add_neg_sat_flag",  64'(flag_a), 64'b110);
    chk("add_neg_wrap_out",  64'(out_b), 64'h7FFF);
    chk("add_neg_wrap_flag", 64'(flag_b), 64'b010);

    issue(4'b0011, 16'h7F80, 16'h0102);
    chk("red_out",  64'(out_a), 64'h0002);
    chk("red_flag", 64'(flag_a), 64'b110);
    issue(4'b1010, 16'hABCD, 16'h0012);
    chk("llb_out", 64'(out_a), 64'hAB12);
    issue(4'b1011, 16'hABCD, 16'h0034);
    chk("lhb_out", 64'(out_a), 64'h34CD);
    issue(4'b1000, 16'h7FFF, 16'h0001);
    chk("lw_out",  64'(out_a), 64'h8000);
    chk("lw_flag", 64'(flag_a), 64'b110);
    issue(4'b0110, 16'h1234, 16'h0000);
    chk("ror0_out", 64'(out_a), 64'h1234);
    issue(4'b1100, 16'h5A5A, 16'h0001);
    chk("b_pass_out", 64'(out_a), 64'h5A5A);
    issue(4'b0100, 16'h8000, 16'h0001);
    chk("sll_out",  64'(out_a), 64'h0000);
    chk("sll_flag", 64'(flag_a), 64'b111);

    // Backpressure: held result, no acceptance while stalled
    out_ready = 1'b0; in_valid = 1'b1; opcode = 4'b0010; in1 = 16'h0001; in2 = 16'h0002;
    #1;
    chk("bp_ready", 64'(rdy_a), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_hold_out", 64'(out_a), 64'h0000);
      chk("bp_hold_vld", 64'(vld_a), 64'd1);
    end
    chk("bp_hold_flag", 64'(flag_a), 64'b111);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(rdy_a), 64'd1);
    step();
    chk("bp_first_out",  64'(out_a), 64'h0003);
    chk("bp_first_flag", 64'(flag_a), 64'b110);
    issue(4'b0000, 16'h0001, 16'h0001);
    chk("bp_second_out",  64'(out_a), 64'h0002);
    chk("bp_second_flag", 64'(flag_a), 64'b000);
    in_valid = 1'b0;
    step();
    chk("drain_vld", 64'(vld_a), 64'd0);

    // Flush wins over a valid input and clears the output
    issue(4'b0000, 16'h0003, 16'h0004);
    chk("pre_flush_out", 64'(out_a), 64'h0007);
    flush = 1'b1; out_ready = 1'b0; opcode = 4'b0000; in1 = 16'h7FFF; in2 = 16'h0001;
    #1;
    chk("flush_ready", 64'(rdy_a), 64'd0);
    step();
    chk("flush_vld",  64'(vld_a), 64'd0);
    chk("flush_flag", 64'(flag_a), 64'b000);
    flush = 1'b0; out_ready = 1'b1;

    // Build flag = 111 with a live result, then async reset mid-cycle
    issue(4'b0000, 16'h8000, 16'hFFFF);
    issue(4'b0010, 16'h0005, 16'h0005);
    issue(4'b1010, 16'hAB00, 16'h0012);
    chk("pre_rst_out",  64'(out_a), 64'hAB12);
    chk("pre_rst_flag", 64'(flag_a), 64'b111);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_vld",  64'(vld_a), 64'd0);
    chk("async_rst_out",  64'(out_a), 64'd0);
    chk("async_rst_flag", 64'(flag_a), 64'd0);
    #1 rst_n = 1'b1;

    // 32-bit instance
    step();
    issue32(4'b0110, 32'h8000_0001, 32'h0000_0001);
    chk("ror32_out",  64'(out32), 64'hC000_0000);
    chk("ror32_flag", 64'(flag32), 64'b000);
    issue32(4'b0101, 32'h8000_0000, 32'h0000_001F);
    chk("sra32_out", 64'(out32), 64'hFFFF_FFFF);
    issue32(4'b0111, 32'h7777_7777, 32'h1111_1111);
    chk("paddsb_pos_out", 64'(out32), 64'h7777_7777);
    issue32(4'b0111, 32'h8888_8888, 32'hFFFF_FFFF);
    chk("paddsb_neg_out", 64'(out32), 64'h8888_8888);
    issue32(4'b0011, 32'h8080_8080, 32'h8080_8080);
    chk("red32_out",  64'(out32), 64'hFFFF_FC00);
    chk("red32_flag", 64'(flag32), 64'b000);
    v32 = 1'b0;
    step();
    chk("drain32_vld", 64'(vld32), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
